// File: rtl/asyncfifo_pkg.sv
// Shared definitions for the asyncfifo write-side arbiter.
// Holds the arbiter state encoding and a constant clog2 helper.
package asyncfifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2, usable for parameter-derived widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request after i_rr_ptr, modulo NREQ.
// Ports: i_req (request vector), i_rr_ptr (last owner), o_any, o_idx.
module rr_pick
    import asyncfifo_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        i_req,
    input  logic [clog2(NREQ)-1:0] i_rr_ptr,
    output logic                   o_any,
    output logic [clog2(NREQ)-1:0] o_idx
);

    localparam int IW = clog2(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IW:0]       w_start;
    logic [IW:0]       w_k;
    logic [IW:0]       w_sum;

    always_comb begin
        // Scan starts one past the last owner, wrapping to 0.
        if (i_rr_ptr == IW'(NREQ - 1)) begin
            w_start = '0;
        end else begin
            w_start = {1'b0, i_rr_ptr} + (IW+1)'(1);
        end

        // Rotate so the scan start lands on bit 0.
        w_dbl = {i_req, i_req};
        w_rot = w_dbl[w_start +: NREQ];

        // Lowest set bit of the rotated vector wins.
        w_k = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_k = (IW+1)'(k);
            end
        end

        // Un-rotate back to a requester index.
        w_sum = w_start + w_k;
        if (w_sum >= (IW+1)'(NREQ)) begin
            o_idx = IW'(w_sum - (IW+1)'(NREQ));
        end else begin
            o_idx = IW'(w_sum);
        end

        o_any = |i_req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked sharing of one asyncfifo write port.
// Ports: wclk/wrst; req_valid/req_data/req_last/req_ready per requester;
//        wfull in; winc/wdata to the FIFO; grant_id and busy status.
module fifo_wr_arbiter
    import asyncfifo_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 8
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [clog2(NREQ)-1:0]  grant_id,
    output logic                    busy
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(MAXBURST) + 1;

    arb_state_t  r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant_id;
    logic [CW-1:0] r_beat_cnt;

    logic          w_any;
    logic [IW-1:0] w_idx;
    logic          w_xfer;
    logic          w_cap;
    logic          w_release;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_any    (w_any),
        .o_idx    (w_idx)
    );

    // Reset gates the handshake so nothing is written or accepted.
    assign w_xfer    = (r_state == ARB_GRANT) & req_valid[r_grant_id]
                     & ~wfull & ~wrst;
    assign w_cap     = (r_beat_cnt == CW'(MAXBURST - 1));
    assign w_release = w_xfer & (req_last[r_grant_id] | w_cap);

    assign winc      = w_xfer;
    assign wdata     = req_data[r_grant_id*DSIZE +: DSIZE];
    assign req_ready = w_xfer ? (NREQ'(1) << r_grant_id) : '0;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ARB_GRANT);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= IW'(NREQ - 1);
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_release) begin
                        r_rr_ptr   <= r_grant_id;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_IDLE;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAXBURST=8).
// Directed scenarios followed by randomized traffic against a reference model.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DS   = 8;
    localparam int MB   = 8;

    logic            wclk;
    logic            wrst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*DS-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic            wfull;
    logic            winc;
    logic [DS-1:0]   wdata;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DS),
        .MAXBURST (MB)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_vec;
    int n_err;

    // requester drivers
    int en[NREQ];
    int plen[NREQ];
    int rem[NREQ];
    int k_drv[NREQ];
    int pv;

    // reference model
    int k_chk[NREQ];
    int m_owner;
    int m_ptr;
    int m_beats;
    int m_gid;
    int wlog[$];

    function automatic logic [7:0] beat(int i, int k);
        return 8'(((i & 3) << 6) | (k & 63));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_update(logic [NREQ-1:0] acc);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && acc[i]) begin
                k_drv[i]++;
                rem[i]--;
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && en[i] != 0 &&
                int'($urandom_range(99)) < pv) begin
                if (rem[i] <= 0) begin
                    rem[i] = (plen[i] > 0) ? plen[i]
                           : int'($urandom_range(1, 12));
                end
                req_valid[i] = 1'b1;
            end
            if (req_valid[i]) begin
                req_data[i*DS +: DS] = beat(i, k_drv[i]);
                req_last[i] = (rem[i] == 1);
            end else begin
                req_data[i*DS +: DS] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance model, then drivers.
    task automatic cyc();
        logic [NREQ-1:0] er;
        logic            ew;
        int              g;
        int              c;
        logic            found;
        @(negedge wclk);
        ew = 1'b0;
        er = '0;
        g  = m_owner;
        if (!wrst && m_owner >= 0) begin
            if (req_valid[g] && !wfull) begin
                ew    = 1'b1;
                er[g] = 1'b1;
            end
        end
        check("winc", 32'(winc), 32'(ew));
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        if (ew) begin
            check("wdata", 32'(wdata), 32'(beat(g, k_chk[g])));
            k_chk[g]++;
            wlog.push_back(g);
        end
        if (wrst) begin
            m_owner = -1;
            m_ptr   = NREQ - 1;
            m_beats = 0;
            m_gid   = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int s = 1; s <= NREQ; s++) begin
                c = (m_ptr + s) % NREQ;
                if (!found && req_valid[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_gid   = c;
                    m_beats = 0;
                end
            end
        end else if (ew) begin
            m_beats++;
            if (req_last[g] || m_beats == MB) begin
                m_ptr   = g;
                m_owner = -1;
            end
        end
        @(posedge wclk);
        #1;
        drv_update(er);
    endtask

    task automatic rst_between();
        wrst  = 1'b1;
        wfull = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]  = 0;
            en[i]   = 0;
            plen[i] = 1;
        end
        cyc();
        wrst = 1'b0;
        wlog.delete();
    endtask

    initial begin
        int exp_q[$];
        logic done;
        int   left;
        n_vec = 0;
        n_err = 0;
        wrst  = 1'b1;
        wfull = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        pv = 100;
        for (int i = 0; i < NREQ; i++) begin
            en[i] = 1; plen[i] = 1; rem[i] = 0;
            k_drv[i] = 0; k_chk[i] = 0;
        end
        drv_update('0);
        @(posedge wclk);
        #1;
        m_owner = -1; m_ptr = NREQ - 1; m_beats = 0; m_gid = 0;

        // T1: reset held with every requester valid
        repeat (3) cyc();
        wrst = 1'b0;
        wlog.delete();

        // T2: round robin, single-beat packets
        repeat (12) cyc();
        check("t2_count", 32'(wlog.size() >= 5), 32'd1);
        exp_q = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check("t2_order", 32'(wlog[i]), 32'(exp_q[i]));

        // T3: burst cap with a 20-beat packet against single beats
        rst_between();
        en[0] = 1; plen[0] = 20;
        en[1] = 1; plen[1] = 1;
        repeat (32) cyc();
        exp_q.delete();
        repeat (8) exp_q.push_back(0);
        exp_q.push_back(1);
        repeat (8) exp_q.push_back(0);
        exp_q.push_back(1);
        repeat (4) exp_q.push_back(0);
        check("t3_count", 32'(wlog.size() >= 22), 32'd1);
        for (int i = 0; i < 22 && i < wlog.size(); i++)
            check("t3_order", 32'(wlog[i]), 32'(exp_q[i]));

        // T4: five-cycle wfull stall mid-packet
        rst_between();
        en[2] = 1; plen[2] = 6;
        done = 1'b0; left = 0;
        for (int c = 0; c < 30; c++) begin
            if (!done && wlog.size() == 2) begin
                done = 1'b1; left = 5;
            end
            wfull = (left > 0);
            if (left > 0) left--;
            cyc();
        end
        check("t4_beats", 32'(wlog.size() >= 6), 32'd1);

        // T5: last beat collides with wfull
        rst_between();
        en[3] = 1; plen[3] = 3;
        done = 1'b0; left = 0;
        for (int c = 0; c < 20; c++) begin
            if (!done && wlog.size() == 2) begin
                done = 1'b1; left = 2;
            end
            wfull = (left > 0);
            if (left > 0) left--;
            cyc();
        end
        wfull = 1'b0;

        // T6: reset during beat 3 of a 6-beat packet
        rst_between();
        en[1] = 1; plen[1] = 6;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            wrst = (!done && wlog.size() == 2);
            if (wrst) done = 1'b1;
            cyc();
        end
        wrst = 1'b0;

        // Randomized traffic with stalls and occasional resets
        rst_between();
        pv = 50;
        for (int i = 0; i < NREQ; i++) begin
            en[i] = 1; plen[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            wfull = (int'($urandom_range(99)) < 20);
            wrst  = ($urandom_range(399) == 0);
            cyc();
        end
        wrst  = 1'b0;
        wfull = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
